piso_serializer: RTL and testbench

Parallel-in/serial-out serializer that consumes the 4-bit parallel word produced by the PIPO register stage and streams it out one bit per enabled clock. It has a one-word holding buffer and a valid/ready input handshake, so back-to-back words stream with no idle bit between them. It sits directly downstream of the parallel register and feeds a serial link or a downstream SIPO stage.

---
 rtl/piso_serializer_if.sv | 24 ++
 rtl/piso_serializer.sv | 95 +++++++++
 tb/tb_piso_serializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - parallel input handshake and serial output bundle for piso_serializer
interface piso_serializer_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] pin;
    logic             pin_valid;
    logic             pin_ready;
    logic             en;
    logic             sout;
    logic             sout_valid;
    logic             sof;
    logic             eof;
    logic             busy;

    modport master (
        output pin, pin_valid, en,
        input  pin_ready, sout, sout_valid, sof, eof, busy
    );

    modport slave (
        input  pin, pin_valid, en,
        output pin_ready, sout, sout_valid, sof, eof, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - 4-bit parallel-in/serial-out shifter with one-word holding buffer
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    piso_serializer_if.slave  bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] sreg_shifted;
    logic             out_bit;
    logic             xfer;

    assign xfer = bus.pin_valid && !hold_full_q;

    // Zero fill from the end opposite the output bit.
    assign sreg_shifted = (MSB_FIRST != 0) ? {sreg_q[WIDTH-2:0], 1'b0}
                                           : {1'b0, sreg_q[WIDTH-1:1]};
    assign out_bit      = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sreg_q      <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    sreg_d  = bus.pin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en && (cnt_q == CNT_LAST)) begin
                    // Last bit leaves: reload from hold, bypass a fresh word, or go idle.
                    if (hold_full_q) begin
                        sreg_d      = hold_q;
                        cnt_d       = '0;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        sreg_d = bus.pin;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (bus.en) begin
                        sreg_d = sreg_shifted;
                        cnt_d  = cnt_q + 1'b1;
                    end
                    if (xfer) begin
                        hold_d      = bus.pin;
                        hold_full_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.pin_ready  = !hold_full_q;
    assign bus.sout_valid = (state_q == SHIFT);
    assign bus.sout       = bus.sout_valid && out_bit;
    assign bus.sof        = bus.sout_valid && (cnt_q == '0);
    assign bus.eof        = bus.sout_valid && (cnt_q == CNT_LAST);
    assign bus.busy       = (state_q == SHIFT) || hold_full_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed vector bench for piso_serializer
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(4)) m_if ();
    piso_serializer_if #(.WIDTH(4)) l_if ();

    assign l_if.pin       = m_if.pin;
    assign l_if.pin_valid = m_if.pin_valid;
    assign l_if.en        = m_if.en;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (.clk(clk), .rst(rst), .bus(m_if.slave));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (.clk(clk), .rst(rst), .bus(l_if.slave));

    typedef struct {
        logic [3:0] pin;
        logic       v;
        logic       en;
        logic       sout;
        logic       sv;
        logic       sof;
        logic       eof;
        logic       busy;
        logic       rdy;
    } vec_t;

    vec_t vecs[32];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic sout, input logic sv, input logic sof,
                           input logic eof, input logic busy, input logic rdy);
        chk({tag, ".sout_valid"}, m_if.sout_valid, sv);
        if (sv) chk({tag, ".sout"}, m_if.sout, sout);
        else    chk({tag, ".sout_idle"}, m_if.sout, 1'b0);
        chk({tag, ".sof"}, m_if.sof, sof);
        chk({tag, ".eof"}, m_if.eof, eof);
        chk({tag, ".busy"}, m_if.busy, busy);
        chk({tag, ".pin_ready"}, m_if.pin_ready, rdy);
    endtask

    task automatic step(input logic [3:0] pin, input logic v, input logic en);
        m_if.pin       = pin;
        m_if.pin_valid = v;
        m_if.en        = en;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] pin, input logic v, input logic en,
                                input logic sout, input logic sv, input logic sof,
                                input logic eof, input logic busy, input logic rdy);
        vec_t r;
        r.pin = pin; r.v = v; r.en = en; r.sout = sout; r.sv = sv;
        r.sof = sof; r.eof = eof; r.busy = busy; r.rdy = rdy;
        return r;
    endfunction

    initial begin
        //                pin      v  en  sout sv sof eof busy rdy
        // single word 1110
        vecs[0]  = mk(4'b1110, 1, 1, 1, 1, 1, 0, 1, 1);
        vecs[1]  = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[2]  = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[3]  = mk(4'b0000, 0, 1, 0, 1, 0, 1, 1, 1);
        vecs[4]  = mk(4'b0000, 0, 1, 0, 0, 0, 0, 0, 1);
        vecs[5]  = mk(4'b0000, 0, 1, 0, 0, 0, 0, 0, 1);
        // back-to-back via hold: 1110 then 0011
        vecs[6]  = mk(4'b1110, 1, 1, 1, 1, 1, 0, 1, 1);
        vecs[7]  = mk(4'b0011, 1, 1, 1, 1, 0, 0, 1, 0);
        vecs[8]  = mk(4'b1111, 0, 1, 1, 1, 0, 0, 1, 0);
        vecs[9]  = mk(4'b1111, 1, 1, 0, 1, 0, 1, 1, 0);
        vecs[10] = mk(4'b0000, 0, 1, 0, 1, 1, 0, 1, 1);
        vecs[11] = mk(4'b0000, 0, 1, 0, 1, 0, 0, 1, 1);
        vecs[12] = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[13] = mk(4'b0000, 0, 1, 1, 1, 0, 1, 1, 1);
        vecs[14] = mk(4'b0000, 0, 1, 0, 0, 0, 0, 0, 1);
        // bypass: 1010 transferred on the last-bit edge
        vecs[15] = mk(4'b1110, 1, 1, 1, 1, 1, 0, 1, 1);
        vecs[16] = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[17] = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[18] = mk(4'b0000, 0, 1, 0, 1, 0, 1, 1, 1);
        vecs[19] = mk(4'b1010, 1, 1, 1, 1, 1, 0, 1, 1);
        vecs[20] = mk(4'b0000, 0, 1, 0, 1, 0, 0, 1, 1);
        vecs[21] = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[22] = mk(4'b0000, 0, 1, 0, 1, 0, 1, 1, 1);
        vecs[23] = mk(4'b0000, 0, 1, 0, 0, 0, 0, 0, 1);
        // stall: en=0 for 3 edges at cnt==1
        vecs[24] = mk(4'b1110, 1, 1, 1, 1, 1, 0, 1, 1);
        vecs[25] = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[26] = mk(4'b0000, 0, 0, 1, 1, 0, 0, 1, 1);
        vecs[27] = mk(4'b0000, 0, 0, 1, 1, 0, 0, 1, 1);
        vecs[28] = mk(4'b0000, 0, 0, 1, 1, 0, 0, 1, 1);
        vecs[29] = mk(4'b0000, 0, 1, 1, 1, 0, 0, 1, 1);
        vecs[30] = mk(4'b0000, 0, 1, 0, 1, 0, 1, 1, 1);
        vecs[31] = mk(4'b0000, 0, 1, 0, 0, 0, 0, 0, 1);

        m_if.pin = '0; m_if.pin_valid = 1'b0; m_if.en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++) begin
            step(vecs[i].pin, vecs[i].v, vecs[i].en);
            chk_out($sformatf("vec%0d", i), vecs[i].sout, vecs[i].sv, vecs[i].sof,
                    vecs[i].eof, vecs[i].busy, vecs[i].rdy);
        end

        // LSB-first instance: 1110 -> 0,1,1,1
        begin
            logic [3:0] lsb_exp;
            lsb_exp = 4'b1110;
            step(4'b1110, 1, 1);
            for (int b = 0; b < 4; b++) begin
                chk($sformatf("lsb.valid%0d", b), l_if.sout_valid, 1'b1);
                chk($sformatf("lsb.sout%0d", b), l_if.sout, lsb_exp[b]);
                chk($sformatf("lsb.sof%0d", b), l_if.sof, b == 0);
                chk($sformatf("lsb.eof%0d", b), l_if.eof, b == 3);
                if (b < 3) step(4'b0000, 0, 1);
            end
            step(4'b0000, 0, 1);
            chk("lsb.idle", l_if.sout_valid, 1'b0);
        end

        // Reset mid-word with hold occupied
        step(4'b1110, 1, 1);
        step(4'b0011, 1, 1);
        chk("rstmid.pre_ready", m_if.pin_ready, 1'b0);
        chk("rstmid.pre_sout", m_if.sout, 1'b1);
        m_if.pin_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_out("rstmid.async", 0, 0, 0, 0, 0, 1);
        chk("rstmid.lsb_valid", l_if.sout_valid, 1'b0);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step(4'b0000, 0, 1);
            chk_out($sformatf("rstmid.quiet%0d", c), 0, 0, 0, 0, 0, 1);
        end
        step(4'b0101, 1, 1);
        chk_out("rstmid.new0", 0, 1, 1, 0, 1, 1);
        step(4'b0000, 0, 1);
        chk_out("rstmid.new1", 1, 1, 0, 0, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
